udp_echo_filter: RTL and testbench
==================================

Name: udp_echo_filter

Overview:
- Parametrised UDP payload loopback that sits between the UDP RX and TX payload streams of the Ethernet stack.
- Each RX frame's header destination port is compared against a table of up to NUM_PORTS ports:
  - matching frames are buffered and echoed on the TX payload stream;
  - non-matching frames are consumed and discarded.
- Adds the following over the fixed-port byte-wide echo:
  - wider data;
  - a per-frame header handshake;
  - store-and-forward frame mode that drops errored or overflowing frames;
  - saturating statistics counters.

Parameters:
- DATA_WIDTH, 8: payload width in bits; must be a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- DEPTH, 4096: FIFO capacity in words; must be a power of two, at least 16.
- NUM_PORTS, 2: number of entries in the accepted-port table, 1..8.
- PORT_LIST, {16'd1235,16'd1234}: NUM_PORTS x 16-bit packed port table; entry i is bits [16i+15:16i].
- FRAME_MODE, 1: 1 = store-and-forward with drop; 0 = cut-through.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_hdr_valid  in  1  RX UDP header valid
- s_hdr_ready  out  1  RX UDP header ready
- s_hdr_dest_port  in  16  RX UDP destination port
- s_axis_tdata  in  DATA_WIDTH  RX payload data
- s_axis_tkeep  in  KEEP_WIDTH  RX payload byte enables
- s_axis_tvalid  in  1  RX payload valid
- s_axis_tready  out  1  RX payload ready
- s_axis_tlast  in  1  RX payload last word of frame
- s_axis_tuser  in  1  RX payload error flag, meaningful on the last word
- m_axis_tdata  out  DATA_WIDTH  TX payload data
- m_axis_tkeep  out  KEEP_WIDTH  TX payload byte enables
- m_axis_tvalid  out  1  TX payload valid
- m_axis_tready  in  1  TX payload ready
- m_axis_tlast  out  1  TX payload last
- m_axis_tuser  out  1  TX payload error flag
- first_word  out  DATA_WIDTH  first word of the most recent frame emitted on TX
- cnt_echoed  out  CNT_WIDTH  frames fully emitted on TX
- cnt_dropped  out  CNT_WIDTH  matched frames dropped (error or overflow)
- cnt_filtered  out  CNT_WIDTH  frames discarded due to port mismatch

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: state IDLE; FIFO empty; all counters 0; first_word 0; m_axis_tvalid 0; s_hdr_ready 1; s_axis_tready 0.
- IDLE state:
  - s_hdr_ready=1 and s_axis_tready=0.
  - A header handshake moves the state to PASS if dest_port equals any PORT_LIST entry, otherwise to DROP. The transition takes effect the next cycle.
- PASS state:
  - s_hdr_ready=0.
  - FRAME_MODE=1: s_axis_tready=1 always.
    - Words go to the FIFO's uncommitted write pointer.
    - If a word arrives when the FIFO is full, the frame is marked overflow; remaining words are accepted and discarded.
    - On the tlast handshake: if tuser=0 and no overflow, commit the pointer, so the whole frame becomes visible to the read side the next cycle. Otherwise roll back to the committed pointer and increment cnt_dropped.
    - Return to IDLE.
  - FRAME_MODE=0: s_axis_tready = not full.
    - Each word is committed immediately.
    - tuser is passed through and nothing is dropped.
    - Return to IDLE after the tlast handshake.
- DROP state:
  - s_axis_tready=1; words are discarded.
  - On the tlast handshake: increment cnt_filtered and return to IDLE.
- A header never overlaps a frame. A header arriving while not IDLE waits, because s_hdr_ready=0.
- Read side:
  - m_axis_tvalid=1 whenever committed data exists.
  - Output is registered; latency from commit to m_axis_tvalid is 1 cycle.
  - Data holds stable while m_axis_tready=0.
- Statistics:
  - On each m_axis handshake with tlast=1, increment cnt_echoed.
  - On the first output word of a frame (tracked by an "in-frame" flag that clears on the tlast handshake), latch tdata into first_word.
- Counters saturate at all-ones and do not wrap.
- Pointers are log2(DEPTH)+1 bits:
  - full when the write pointer minus the read pointer equals DEPTH;
  - wrap-around is handled by the extra MSB.
- Simultaneous read and write on the same cycle are both permitted, including when full (FRAME_MODE=0: write blocked when full, read proceeds).
- A frame larger than DEPTH in FRAME_MODE=1 is always dropped. It never deadlocks.
- Reset mid-frame: the partial frame is discarded and the state machine returns to IDLE. Subsequent words before the next header are ignored (s_axis_tready=0 in IDLE, so they stall upstream).

Decomposition:
- Package udp_echo_pkg:
  - state enum {IDLE, PASS, DROP};
  - port_match function (dest_port, PORT_LIST, NUM_PORTS) returning 1 bit;
  - counter saturating-increment function.
- Sub-module udp_echo_frame_fifo contains:
  - the RAM;
  - write, committed-write and read pointers;
  - commit/rollback inputs;
  - overflow flag;
  - registered output stage.
- The top level holds the header FSM, filter, counters and first_word capture.

Test Plan:
- Port 1234, 4-byte frame 0x11,0x22,0x33,0x44 with tuser=0; m_axis_tready=1.
  - Required: identical 4 bytes out, tlast on 0x44; cnt_echoed=1; first_word=0x11.
- Port 80, 10-byte frame.
  - Required: s_axis_tready=1 throughout; no TX output; cnt_filtered=1.
- FRAME_MODE=1, port 1235, 6 bytes ending with tuser=1.
  - Required: no TX output; cnt_dropped=1.
  - Then a clean 2-byte frame 0xAA,0xBB is echoed correctly.
- DEPTH=16, FRAME_MODE=1, 20-byte matched frame, then a 3-byte matched frame.
  - Required: first frame dropped (cnt_dropped=1); second frame echoed.
- m_axis_tready toggled 1/0 every cycle across three back-to-back 5-byte matched frames.
  - Required: 15 bytes out in order, data stable while stalled; cnt_echoed=3.
- Assert rst on the 3rd byte of a matched 8-byte frame.
  - Required: all counters and first_word 0; no TX output; the next header is accepted in IDLE.

Source files
------------

// File: rtl/udp_echo_pkg.sv
// udp_echo_pkg: shared state type, port-table match and saturating counter helpers
package udp_echo_pkg;
    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    function automatic logic port_match(input logic [15:0] port, input logic [127:0] list, input int n);
        port_match = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i < n && list[16*i +: 16] == port) port_match = 1'b1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] m;
        m = (w >= 32) ? 32'hffff_ffff : (32'h1 << w) - 32'h1;
        return (v == m) ? v : v + 32'h1;
    endfunction
endpackage

// File: rtl/udp_echo_frame_fifo.sv
// udp_echo_frame_fifo: frame FIFO with commit/rollback write side and registered read stage
module udp_echo_frame_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH = 4096,
    parameter int FRAME_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    input  logic                  in_last,
    input  logic                  in_user,
    output logic                  full,
    output logic                  drop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [KEEP_WIDTH-1:0] out_keep,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  out_user
);
    localparam int AW = $clog2(DEPTH);
    localparam int WW = DATA_WIDTH + KEEP_WIDTH + 2;
    logic [WW-1:0] mem [DEPTH];
    logic [WW-1:0] out_word;
    logic [AW:0] wr_ptr, commit_ptr, rd_ptr;
    logic ovf, write, bad, load;
    assign full = (wr_ptr - rd_ptr) == (AW+1)'(DEPTH);
    assign write = in_valid && !full;
    assign bad = in_user || ovf || full;
    assign drop = FRAME_MODE != 0 && in_valid && in_last && bad;
    assign load = (rd_ptr != commit_ptr) && (!out_valid || out_ready);
    assign {out_data, out_keep, out_last, out_user} = out_word;
    always_ff @(posedge clk)
        if (write) mem[wr_ptr[AW-1:0]] <= {in_data, in_keep, in_last, in_user};
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            commit_ptr <= '0;
            rd_ptr <= '0;
            ovf <= 1'b0;
            out_valid <= 1'b0;
            out_word <= '0;
        end else begin
            if (FRAME_MODE == 0) begin
                if (write) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    commit_ptr <= wr_ptr + 1'b1;
                end
            end else if (in_valid) begin
                // an errored or overflowed frame rewinds to the last committed frame boundary
                if (in_last) begin
                    ovf <= 1'b0;
                    if (bad) wr_ptr <= commit_ptr;
                    else begin
                        wr_ptr <= wr_ptr + 1'b1;
                        commit_ptr <= wr_ptr + 1'b1;
                    end
                end else if (full) ovf <= 1'b1;
                else wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                out_word <= mem[rd_ptr[AW-1:0]];
                rd_ptr <= rd_ptr + 1'b1;
                out_valid <= 1'b1;
            end else if (out_ready) out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/udp_echo_filter.sv
// udp_echo_filter: port-filtered UDP payload echo with frame drop and statistics
module udp_echo_filter
    import udp_echo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH = 4096,
    parameter int NUM_PORTS = 2,
    parameter logic [16*NUM_PORTS-1:0] PORT_LIST = {16'd1235, 16'd1234},
    parameter int FRAME_MODE = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_hdr_valid,
    output logic                  s_hdr_ready,
    input  logic [15:0]           s_hdr_dest_port,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic [DATA_WIDTH-1:0] first_word,
    output logic [CNT_WIDTH-1:0]  cnt_echoed,
    output logic [CNT_WIDTH-1:0]  cnt_dropped,
    output logic [CNT_WIDTH-1:0]  cnt_filtered
);
    state_t state, state_n;
    logic full, drop, in_last_hs, out_hs, in_frame;
    assign in_last_hs = s_axis_tvalid && s_axis_tready && s_axis_tlast;
    assign out_hs = m_axis_tvalid && m_axis_tready;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;
    always_comb begin
        s_hdr_ready = state == IDLE;
        s_axis_tready = (state == DROP) || (state == PASS && (FRAME_MODE != 0 || !full));
        state_n = state;
        if (state == IDLE)
            state_n = s_hdr_valid ? (port_match(s_hdr_dest_port, 128'(PORT_LIST), NUM_PORTS) ? PASS : DROP) : IDLE;
        else if (in_last_hs)
            state_n = IDLE;
    end
    udp_echo_frame_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .KEEP_WIDTH(KEEP_WIDTH),
        .DEPTH(DEPTH),
        .FRAME_MODE(FRAME_MODE)
    ) fifo (
        .clk(clk),
        .rst(rst),
        .in_valid(state == PASS && s_axis_tvalid && s_axis_tready),
        .in_data(s_axis_tdata),
        .in_keep(s_axis_tkeep),
        .in_last(s_axis_tlast),
        .in_user(s_axis_tuser),
        .full(full),
        .drop(drop),
        .out_data(m_axis_tdata),
        .out_keep(m_axis_tkeep),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready),
        .out_last(m_axis_tlast),
        .out_user(m_axis_tuser)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_echoed <= '0;
            cnt_dropped <= '0;
            cnt_filtered <= '0;
            first_word <= '0;
            in_frame <= 1'b0;
        end else begin
            if (out_hs && m_axis_tlast) cnt_echoed <= CNT_WIDTH'(sat_inc(32'(cnt_echoed), CNT_WIDTH));
            if (drop) cnt_dropped <= CNT_WIDTH'(sat_inc(32'(cnt_dropped), CNT_WIDTH));
            if (state == DROP && in_last_hs) cnt_filtered <= CNT_WIDTH'(sat_inc(32'(cnt_filtered), CNT_WIDTH));
            if (out_hs) begin
                if (!in_frame) first_word <= m_axis_tdata;
                in_frame <= !m_axis_tlast;
            end
        end
    end
endmodule

// File: tb/tb_udp_echo_filter.sv
// tb_udp_echo_filter: scoreboard bench for the port-filtered UDP echo
module tb_udp_echo_filter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_hdr_valid = 1'b0;
    logic s_hdr_ready;
    logic [15:0] s_hdr_dest_port = '0;
    logic [7:0] s_axis_tdata = '0;
    logic [0:0] s_axis_tkeep = 1'b1;
    logic s_axis_tvalid = 1'b0;
    logic s_axis_tready;
    logic s_axis_tlast = 1'b0;
    logic s_axis_tuser = 1'b0;
    logic [7:0] m_axis_tdata;
    logic [0:0] m_axis_tkeep;
    logic m_axis_tvalid;
    logic m_axis_tready;
    logic m_axis_tlast;
    logic m_axis_tuser;
    logic [7:0] first_word;
    logic [15:0] cnt_echoed, cnt_dropped, cnt_filtered;

    int checks = 0;
    int errors = 0;
    int stalls;
    logic toggle_en = 1'b0;
    logic [9:0] q[$];

    always #5 clk = ~clk;

    udp_echo_filter #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr_dest_port(s_hdr_dest_port),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .first_word(first_word), .cnt_echoed(cnt_echoed), .cnt_dropped(cnt_dropped),
        .cnt_filtered(cnt_filtered)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m_axis_tready = toggle_en ? ~m_axis_tready : 1'b1;
        end
    end

    // monitor: pops the scoreboard on every output handshake and checks hold-while-stalled
    initial begin
        logic held_v;
        logic [9:0] held_d, exp;
        held_v = 1'b0;
        held_d = '0;
        forever begin
            @(negedge clk);
            if (!rst && m_axis_tvalid) begin
                if (held_v) chk("stable_while_stalled", {22'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata}, {22'd0, held_d});
                if (m_axis_tready) begin
                    held_v = 1'b0;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected none", m_axis_tdata);
                    end else begin
                        exp = q.pop_front();
                        chk("tx_word", {22'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata}, {22'd0, exp});
                    end
                end else begin
                    held_v = 1'b1;
                    held_d = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
                end
            end else held_v = 1'b0;
        end
    end

    task automatic send_frame(input logic [15:0] port, input int n, input logic [7:0] base,
                              input logic [7:0] step, input logic user, input logic exp);
        logic [7:0] d;
        int t;
        s_hdr_valid = 1'b1;
        s_hdr_dest_port = port;
        t = 0;
        @(negedge clk);
        while (!s_hdr_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!s_hdr_ready) chk("hdr_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 s_hdr_valid = 1'b0;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            d = base + step * 8'(i);
            s_axis_tdata = d;
            s_axis_tlast = (i == n - 1);
            s_axis_tuser = (i == n - 1) ? user : 1'b0;
            s_axis_tvalid = 1'b1;
            if (exp) q.push_back({i == n - 1, 1'b0, d});
            t = 0;
            @(negedge clk);
            while (!s_axis_tready && t < 100) begin
                stalls++;
                t++;
                @(negedge clk);
            end
            if (!s_axis_tready) chk("word_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tuser = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || m_axis_tvalid) && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        if (t >= 300) chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hdr_ready", 32'(s_hdr_ready), 32'd1);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_counters", {cnt_echoed, cnt_dropped}, 32'd0);
        chk("rst_filtered", 32'(cnt_filtered), 32'd0);
        chk("rst_first_word", 32'(first_word), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        send_frame(16'd1234, 4, 8'h11, 8'h11, 1'b0, 1'b1);
        drain();
        chk("echo_cnt", 32'(cnt_echoed), 32'd1);
        chk("echo_first_word", 32'(first_word), 32'h11);

        send_frame(16'd80, 10, 8'h30, 8'h01, 1'b0, 1'b0);
        chk("filter_stalls", 32'(stalls), 32'd0);
        drain();
        chk("filter_cnt", 32'(cnt_filtered), 32'd1);

        send_frame(16'd1235, 6, 8'h60, 8'h01, 1'b1, 1'b0);
        drain();
        chk("err_drop_cnt", 32'(cnt_dropped), 32'd1);
        send_frame(16'd1234, 2, 8'hAA, 8'h11, 1'b0, 1'b1);
        drain();
        chk("after_err_echo_cnt", 32'(cnt_echoed), 32'd2);
        chk("after_err_first_word", 32'(first_word), 32'hAA);

        send_frame(16'd1234, 20, 8'h80, 8'h01, 1'b0, 1'b0);
        drain();
        chk("ovf_drop_cnt", 32'(cnt_dropped), 32'd2);
        send_frame(16'd1235, 3, 8'hC0, 8'h01, 1'b0, 1'b1);
        drain();
        chk("after_ovf_echo_cnt", 32'(cnt_echoed), 32'd3);
        chk("after_ovf_first_word", 32'(first_word), 32'hC0);

        toggle_en = 1'b1;
        send_frame(16'd1234, 5, 8'h01, 8'h01, 1'b0, 1'b1);
        send_frame(16'd1235, 5, 8'h21, 8'h01, 1'b0, 1'b1);
        send_frame(16'd1234, 5, 8'h41, 8'h01, 1'b0, 1'b1);
        drain();
        toggle_en = 1'b0;
        chk("b2b_echo_cnt", 32'(cnt_echoed), 32'd6);
        chk("b2b_first_word", 32'(first_word), 32'h41);

        s_hdr_valid = 1'b1;
        s_hdr_dest_port = 16'd1234;
        @(posedge clk);
        #1 s_hdr_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_axis_tdata = 8'(i + 1);
            s_axis_tvalid = 1'b1;
            @(posedge clk);
            #1;
        end
        s_axis_tdata = 8'h03;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_counters", {cnt_echoed, cnt_dropped}, 32'd0);
        chk("midrst_filtered", 32'(cnt_filtered), 32'd0);
        chk("midrst_first_word", 32'(first_word), 32'd0);
        chk("midrst_m_valid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_hdr_ready", 32'(s_hdr_ready), 32'd1);
        chk("midrst_tready", 32'(s_axis_tready), 32'd0);
        @(posedge clk);
        #1 s_axis_tvalid = 1'b0;
        send_frame(16'd1234, 3, 8'h50, 8'h01, 1'b0, 1'b1);
        drain();
        chk("midrst_echo_cnt", 32'(cnt_echoed), 32'd1);
        chk("midrst_echo_first_word", 32'(first_word), 32'h50);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
